// File: rtl/ring_nic_pkg.sv
// Shared definitions for the ring NIC and the ring router.
package ring_nic_pkg;

    localparam int DATA_WIDTH = 64;

    localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

endpackage

// File: rtl/nic_channel_buf.sv
// Single-entry packet buffer with load/consume handshake; load wins if both fire.
module nic_channel_buf #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    input  logic                  consume_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = load_data_i;
        end else if (consume_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/ring_nic.sv
// NIC between a PE and its ring router: register decode, in/out buffers, polarity-gated injection.
module ring_nic #(
    parameter int DATA_WIDTH = ring_nic_pkg::DATA_WIDTH,
    parameter int VC_BIT     = DATA_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nic_en,
    input  logic                  nic_wr_en,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_polarity
);

    import ring_nic_pkg::*;

    logic                  rd, wr;
    logic                  in_full, out_full;
    logic [DATA_WIDTH-1:0] in_buf, out_buf;
    logic                  in_load, in_consume, out_load, out_consume;
    logic [DATA_WIDTH-1:0] d_out_q, d_out_d;

    assign rd = nic_en & ~nic_wr_en;
    assign wr = nic_en & nic_wr_en;

    assign net_ri     = ~in_full;
    assign in_load    = net_si & net_ri;
    assign in_consume = rd & (addr == ADDR_IN_BUF) & in_full;

    // Injection only on the virtual-channel phase matching the packet's tag.
    assign net_so      = out_full & (out_buf[VC_BIT] == net_polarity);
    assign out_consume = net_so & net_ro;
    assign out_load    = wr & (addr == ADDR_OUT_BUF) & ~out_full;
    assign net_do      = out_buf;

    nic_channel_buf #(.DATA_WIDTH(DATA_WIDTH)) u_in_buf (
        .clk         (clk),
        .reset       (reset),
        .load_i      (in_load),
        .load_data_i (net_di),
        .consume_i   (in_consume),
        .valid_o     (in_full),
        .data_o      (in_buf)
    );

    nic_channel_buf #(.DATA_WIDTH(DATA_WIDTH)) u_out_buf (
        .clk         (clk),
        .reset       (reset),
        .load_i      (out_load),
        .load_data_i (d_in),
        .consume_i   (out_consume),
        .valid_o     (out_full),
        .data_o      (out_buf)
    );

    always_comb begin
        d_out_d = '0;
        if (rd) begin
            unique case (addr)
                ADDR_IN_BUF:   d_out_d = in_buf;
                ADDR_IN_STAT:  d_out_d = {{(DATA_WIDTH-1){1'b0}}, in_full};
                ADDR_OUT_BUF:  d_out_d = '0;
                ADDR_OUT_STAT: d_out_d = {{(DATA_WIDTH-1){1'b0}}, out_full};
                default:       d_out_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) d_out_q <= '0;
        else       d_out_q <= d_out_d;
    end

    assign d_out = d_out_q;

endmodule
